// File: rtl/sprite_player_pkg.sv
// Shared constants and types for the sprite engine: direction bit indices,
// FSM state encodings and default display geometry.
package sprite_player_pkg;

    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

    localparam int H_DISP = 640;
    localparam int V_DISP = 480;

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_INVINC = 2'd1,
        ST_DEAD   = 2'd2
    } state_e;

endpackage

// File: rtl/sprite_player_if.sv
// Pixel request / sprite ROM / compositor bus of a sprite engine.
// The master side is the sprite engine, the slave side is the ROM plus compositor.
interface sprite_player_if #(
    parameter int X_W    = 10,
    parameter int Y_W    = 10,
    parameter int ADDR_W = 14,
    parameter int GRAY_W = 4
);
    logic [X_W-1:0]      req_x_addr_i;
    logic [Y_W-1:0]      req_y_addr_i;
    logic                rom_rd_o;
    logic [ADDR_W-1:0]   rom_addr_o;
    logic [GRAY_W:0]     rom_data_i;
    logic [3*GRAY_W-1:0] vga_rgb_o;
    logic                vga_alpha_o;

    modport master (
        input  req_x_addr_i, req_y_addr_i, rom_data_i,
        output rom_rd_o, rom_addr_o, vga_rgb_o, vga_alpha_o
    );

    modport slave (
        output req_x_addr_i, req_y_addr_i, rom_data_i,
        input  rom_rd_o, rom_addr_o, vga_rgb_o, vga_alpha_o
    );
endinterface

// File: rtl/sprite_player_addr_gen.sv
// sprite_addr_gen: sprite area test, ROM offset address and the 1-cycle in_area
// alignment flop matching a registered ROM. Reusable by any rectangular sprite.
module sprite_addr_gen #(
    parameter int X_W    = 10,
    parameter int Y_W    = 10,
    parameter int SPR_W  = 102,
    parameter int SPR_H  = 126,
    parameter int ADDR_W = 14
) (
    input  logic              clk_vga,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              visible_i,
    input  logic [X_W-1:0]    x_pos_i,
    input  logic [Y_W-1:0]    y_pos_i,
    input  logic [X_W-1:0]    req_x_i,
    input  logic [Y_W-1:0]    req_y_i,
    output logic              rom_rd_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              in_area_q_o
);

    logic [X_W:0]      x_lo, x_hi, rx;
    logic [Y_W:0]      y_lo, y_hi, ry;
    logic [X_W-1:0]    dx;
    logic [Y_W-1:0]    dy;
    logic              in_area;
    logic              in_area_d, in_area_q;

    // One extra bit so x_pos+SPR_W near the right edge cannot wrap.
    assign rx   = {1'b0, req_x_i};
    assign ry   = {1'b0, req_y_i};
    assign x_lo = {1'b0, x_pos_i};
    assign y_lo = {1'b0, y_pos_i};
    assign x_hi = x_lo + (X_W+1)'(SPR_W);
    assign y_hi = y_lo + (Y_W+1)'(SPR_H);

    assign in_area = en_i && visible_i &&
                     (rx >= x_lo) && (rx < x_hi) &&
                     (ry >= y_lo) && (ry < y_hi);

    assign dx = req_x_i - x_pos_i;
    assign dy = req_y_i - y_pos_i;

    always_comb begin
        rom_rd_o   = in_area;
        rom_addr_o = '0;
        if (in_area) begin
            rom_addr_o = ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx);
        end
    end

    assign in_area_d = in_area;

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            in_area_q <= 1'b0;
        end else begin
            in_area_q <= in_area_d;
        end
    end

    assign in_area_q_o = in_area_q;

endmodule

// File: rtl/sprite_player.sv
// Player sprite engine: position with 8-way clamped movement, hit/lives/invincibility
// FSM and a 1-cycle-latency pixel stream from an external ROM. Optional: SPRITE_BLINK_EN.
//
// state     | meaning
// ST_ALIVE  | normal play; moves on frame ticks, a hit costs a life
// ST_INVINC | post-hit/revive grace period; moves, ignores hits, counts down inv_cnt
// ST_DEAD   | no lives left; hidden, frozen, waits for revive_i
module sprite_player #(
    parameter int X_W          = 10,
    parameter int Y_W          = 10,
    parameter int H_DISP       = sprite_player_pkg::H_DISP,
    parameter int V_DISP       = sprite_player_pkg::V_DISP,
    parameter int SPR_W        = 102,
    parameter int SPR_H        = 126,
    parameter int ADDR_W       = 14,
    parameter int GRAY_W       = 4,
    parameter int SPEED        = 5,
    parameter int INIT_X       = 269,
    parameter int INIT_Y       = 340,
    parameter int LIVES        = 3,
    parameter int INV_FRAMES   = 120,
    parameter int BLINK_FRAMES = 8
) (
    input  logic            clk_vga,
    input  logic            rst_n,
    input  logic            en_i,
    input  logic            frame_tick_i,
    input  logic [3:0]      dir_i,
    input  logic            hit_i,
    input  logic            revive_i,
    sprite_player_if.master bus,
    output logic [X_W-1:0]  x_pos_o,
    output logic [Y_W-1:0]  y_pos_o,
    output logic [3:0]      lives_o,
    output logic            invincible_o,
    output logic            dead_o
);
    import sprite_player_pkg::*;

    localparam int INV_W = (INV_FRAMES > 1) ? $clog2(INV_FRAMES + 1) : 1;

    localparam logic [X_W:0]     X_MAX  = (X_W+1)'(H_DISP - SPR_W);
    localparam logic [Y_W:0]     Y_MAX  = (Y_W+1)'(V_DISP - SPR_H);
    localparam logic [X_W:0]     SPD_X  = (X_W+1)'(SPEED);
    localparam logic [Y_W:0]     SPD_Y  = (Y_W+1)'(SPEED);
    localparam logic [X_W-1:0]   X_INIT = X_W'(INIT_X);
    localparam logic [Y_W-1:0]   Y_INIT = Y_W'(INIT_Y);
    localparam logic [3:0]       LIVES_INIT = 4'(LIVES);
    localparam logic [INV_W-1:0] INV_LOAD   = INV_W'(INV_FRAMES);

    state_e           state_q, state_d;
    logic [3:0]       lives_q, lives_d;
    logic [INV_W-1:0] inv_cnt_q, inv_cnt_d;
    logic [X_W-1:0]   x_q, x_d, x_step;
    logic [Y_W-1:0]   y_q, y_d, y_step;
    logic [X_W:0]     x_ext, x_sum;
    logic [Y_W:0]     y_ext, y_sum;
    logic             visible;
    logic             area_q;

    assign x_ext = {1'b0, x_q};
    assign y_ext = {1'b0, y_q};
    assign x_sum = x_ext + SPD_X;
    assign y_sum = y_ext + SPD_Y;

    // Opposite directions cancel; each axis saturates at its bound.
    always_comb begin
        x_step = x_q;
        if (dir_i[DIR_LEFT] && !dir_i[DIR_RIGHT]) begin
            x_step = (x_ext < SPD_X) ? '0 : X_W'(x_ext - SPD_X);
        end else if (dir_i[DIR_RIGHT] && !dir_i[DIR_LEFT]) begin
            x_step = (x_sum > X_MAX) ? X_W'(X_MAX) : X_W'(x_sum);
        end
    end

    always_comb begin
        y_step = y_q;
        if (dir_i[DIR_UP] && !dir_i[DIR_DOWN]) begin
            y_step = (y_ext < SPD_Y) ? '0 : Y_W'(y_ext - SPD_Y);
        end else if (dir_i[DIR_DOWN] && !dir_i[DIR_UP]) begin
            y_step = (y_sum > Y_MAX) ? Y_W'(Y_MAX) : Y_W'(y_sum);
        end
    end

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ALIVE;
            lives_q   <= LIVES_INIT;
            inv_cnt_q <= '0;
            x_q       <= X_INIT;
            y_q       <= Y_INIT;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            inv_cnt_q <= inv_cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        inv_cnt_d = inv_cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        if (en_i) begin
            if (frame_tick_i && (state_q != ST_DEAD)) begin
                x_d = x_step;
                y_d = y_step;
            end
            case (state_q)
                ST_ALIVE: begin
                    if (hit_i) begin
                        if (lives_q > 4'd1) begin
                            lives_d   = lives_q - 4'd1;
                            inv_cnt_d = INV_LOAD;
                            state_d   = ST_INVINC;
                        end else begin
                            lives_d = 4'd0;
                            state_d = ST_DEAD;
                        end
                    end
                end
                ST_INVINC: begin
                    if (frame_tick_i) begin
                        if (inv_cnt_q <= INV_W'(1)) begin
                            inv_cnt_d = '0;
                            state_d   = ST_ALIVE;
                        end else begin
                            inv_cnt_d = inv_cnt_q - INV_W'(1);
                        end
                    end
                end
                ST_DEAD: begin
                    if (revive_i) begin
                        lives_d   = LIVES_INIT;
                        x_d       = X_INIT;
                        y_d       = Y_INIT;
                        inv_cnt_d = INV_LOAD;
                        state_d   = ST_INVINC;
                    end
                end
                default: state_d = ST_ALIVE;
            endcase
        end
    end

`ifdef SPRITE_BLINK_EN
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLK_W-1:0] BLK_LOAD = BLK_W'(BLINK_FRAMES - 1);

    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             hidden_q, hidden_d;

    // Entering INVINC always restarts in the visible phase.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        hidden_d    = hidden_q;
        if (en_i) begin
            if ((state_d == ST_INVINC) && (state_q != ST_INVINC)) begin
                blink_cnt_d = BLK_LOAD;
                hidden_d    = 1'b0;
            end else if ((state_q == ST_INVINC) && frame_tick_i) begin
                if (blink_cnt_q == '0) begin
                    blink_cnt_d = BLK_LOAD;
                    hidden_d    = !hidden_q;
                end else begin
                    blink_cnt_d = blink_cnt_q - BLK_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            hidden_q    <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            hidden_q    <= hidden_d;
        end
    end
`endif

    always_comb begin
        invincible_o = (state_q == ST_INVINC);
        dead_o       = (state_q == ST_DEAD);
`ifdef SPRITE_BLINK_EN
        visible      = (state_q != ST_DEAD) && !((state_q == ST_INVINC) && hidden_q);
`else
        visible      = (state_q != ST_DEAD);
`endif
        bus.vga_rgb_o   = '0;
        bus.vga_alpha_o = 1'b0;
        if (area_q) begin
            bus.vga_rgb_o   = {3{bus.rom_data_i[GRAY_W:1]}};
            bus.vga_alpha_o = bus.rom_data_i[0];
        end
    end

    sprite_addr_gen #(
        .X_W    (X_W),
        .Y_W    (Y_W),
        .SPR_W  (SPR_W),
        .SPR_H  (SPR_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk_vga     (clk_vga),
        .rst_n       (rst_n),
        .en_i        (en_i),
        .visible_i   (visible),
        .x_pos_i     (x_q),
        .y_pos_i     (y_q),
        .req_x_i     (bus.req_x_addr_i),
        .req_y_i     (bus.req_y_addr_i),
        .rom_rd_o    (bus.rom_rd_o),
        .rom_addr_o  (bus.rom_addr_o),
        .in_area_q_o (area_q)
    );

    assign x_pos_o = x_q;
    assign y_pos_o = y_q;
    assign lives_o = lives_q;

endmodule
